syllable_parity_check: RTL and testbench
========================================

Name: syllable_parity_check

Overview:
- Upstream stage of the error-detection/switchover logic.
- Accumulates serial read data from duplex memory channels A and B over one syllable (DATA_BITS data bits plus 1 parity bit).
- Checks the parity of each channel and compares the two channels bit-for-bit.
- Emits per-channel parity-error flags (EAP, EBP), agree/disagree flags (COC, CNC) and a one-clock TIME check strobe, all consumed by the switchover block.

Parameters:
- DATA_BITS, 13, data bits per syllable; the parity bit follows as bit DATA_BITS.
- ODD_PARITY, 1, 1 = a correct syllable has an odd count of ones over data+parity; 0 = even.
- CNT_W, 4, counter width; must satisfy 2^CNT_W > DATA_BITS.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- SYNC  in  1  start-of-syllable strobe; one clk wide, coincides with bit 0.
- BITEN  in  1  bit-time strobe; serial inputs are sampled only when high.
- SAA  in  1  serial sense-amp data, channel A.
- SAB  in  1  serial sense-amp data, channel B.
- CLRERR  in  1  clears held flags.
- TIME  out  1  one-clk strobe when a syllable check completes.
- EAP  out  1  channel A parity error, held.
- EBP  out  1  channel B parity error, held.
- COC  out  1  channels agreed on every bit of the last syllable, held.
- CNC  out  1  channels disagreed on at least one bit, held.
- BUSY  out  1  high while in SHIFT.

Behaviour:
- Reset (rst=1 at edge): state IDLE, counter 0, accumulators cleared, all outputs 0. rst overrides every other input.
- Registers:
  - pa, pb: running XOR of SAA / SAB.
  - dif: sticky OR of (SAA ^ SAB).
  - cnt: bits accepted.
- IDLE:
  - Exits only on SYNC&BITEN. That edge samples bit 0: pa<=SAA, pb<=SAB, dif<=SAA^SAB, cnt<=1, go to SHIFT.
  - SYNC without BITEN is ignored.
- SHIFT:
  - Each BITEN: pa^=SAA, pb^=SAB, dif|=SAA^SAB, cnt+=1.
  - When the bit with cnt==DATA_BITS (the parity bit) is accepted, go to CHECK on the next edge.
- SYNC&BITEN while in SHIFT: abort the current syllable with no check outputs, and restart per the IDLE entry rule in the same edge.
- CHECK (exactly one clk):
  - TIME=1.
  - EAP <= pa ^ ODD_PARITY; EBP <= pb ^ ODD_PARITY (1 = error).
  - CNC <= dif; COC <= ~dif.
  - Next state IDLE. If SYNC&BITEN arrives during CHECK, the check still completes and the next state is SHIFT with bit 0 sampled (back-to-back syllables).
- Latency:
  - EAP, EBP, COC and CNC update on the edge that leaves CHECK, and are valid in the same cycle TIME is high.
  - They are held until the next CHECK, CLRERR or rst.
- CLRERR: clears EAP, EBP, COC and CNC at the edge. If CLRERR coincides with the CHECK update, the check update wins.
- BITEN low: the state holds; there is no timeout.
- COC and CNC are both 0 after reset or CLRERR, until the first check.

Optional Feature:
- Macro: SYLLABLE_ERR_COUNT_EN.
- With the macro defined:
  - Adds outputs ECNTA[7:0] and ECNTB[7:0].
  - Each counter increments by 1 on every CHECK that sets the corresponding parity-error flag, and saturates at 255.
  - Both counters clear on rst only; CLRERR does not affect them.
- Without the macro: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Reset: assert rst for 2 clks mid-SHIFT -> all outputs 0, BUSY=0; a following syllable checks normally.
- Clean syllable: ODD_PARITY=1, both channels send 0x0001 data with parity 0 (one 1 total), BITEN every clk -> TIME pulses 1 clk after the parity bit; EAP=0, EBP=0, COC=1, CNC=0.
- Channel-A error: same stimulus but A bit 5 flipped -> EAP=1, EBP=0, CNC=1, COC=0; flags hold until CLRERR, which drives all four to 0.
- Abort: SYNC&BITEN at cnt==7 -> no TIME for the first syllable; the restarted syllable yields TIME exactly 14 BITEN strobes plus 1 clk after the second SYNC.
- Back-to-back with gaps: BITEN every 3rd clk; next SYNC during CHECK -> TIME pulses once per syllable, no bit lost; flags correct for a 0x1FFF/parity-0 syllable (EAP=EBP=0).
- SYLLABLE_ERR_COUNT_EN: 300 consecutive A-parity-error syllables -> ECNTA=255, ECNTB=0; CLRERR leaves ECNTA=255; rst -> 0.

Source files
------------

// File: rtl/syllable_parity_check.sv
// ----------------------------------------------------------------------------
// syllable_parity_check
//
// Accumulates one serial syllable (DATA_BITS data bits followed by one parity
// bit) from each of the duplex memory channels A and B. When the syllable is
// complete it checks parity on each channel and compares the two channels
// bit-for-bit. The results are handed to the switchover block.
//
// Optional build macro: SYLLABLE_ERR_COUNT_EN
//   This macro adds the saturating 8-bit parity-error counters ECNTA/ECNTB.
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   synchronous reset, active high
//   SYNC    in   start-of-syllable strobe, coincides with bit 0
//   BITEN   in   bit-time strobe; SAA/SAB are sampled only when high
//   SAA     in   serial data, channel A
//   SAB     in   serial data, channel B
//   CLRERR  in   clears the held EAP/EBP/COC/CNC flags
//   TIME    out  one-clock strobe; the flags are valid in this cycle
//   EAP     out  channel A parity error (held)
//   EBP     out  channel B parity error (held)
//   COC     out  channels agreed on every bit of the last syllable (held)
//   CNC     out  channels disagreed on at least one bit (held)
//   BUSY    out  high while a syllable is being shifted in
//   ECNTA   out  [7:0] channel A parity-error count (macro only)
//   ECNTB   out  [7:0] channel B parity-error count (macro only)
// ----------------------------------------------------------------------------
module syllable_parity_check #(
    parameter int DATA_BITS  = 13,
    parameter int ODD_PARITY = 1,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SYNC,
    input  logic       BITEN,
    input  logic       SAA,
    input  logic       SAB,
    input  logic       CLRERR,
    output logic       TIME,
    output logic       EAP,
    output logic       EBP,
    output logic       COC,
    output logic       CNC,
    output logic       BUSY
`ifdef SYLLABLE_ERR_COUNT_EN
    ,
    output logic [7:0] ECNTA,
    output logic [7:0] ECNTB
`endif
);

    localparam logic [1:0]       ST_IDLE  = 2'd0;
    localparam logic [1:0]       ST_SHIFT = 2'd1;
    localparam logic [1:0]       ST_CHECK = 2'd2;
    // cnt value while the parity bit is being accepted
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic             ODD_BIT  = (ODD_PARITY != 0) ? 1'b1 : 1'b0;

    // The accumulator is the XOR of all received bits, which is 1 for an odd count of ones.
    // The result is an error whenever that value differs from the expected sense.
    function automatic logic parity_err(input logic acc);
        return acc ^ ODD_BIT;
    endfunction

    logic [1:0]       state_r;
    logic [1:0]       state_nx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nx_s;
    logic             pa_r;
    logic             pa_nx_s;
    logic             pb_r;
    logic             pb_nx_s;
    logic             dif_r;
    logic             dif_nx_s;
    logic             start_s;

    logic             time_r;
    logic             eap_r;
    logic             ebp_r;
    logic             coc_r;
    logic             cnc_r;
    logic             busy_r;

    // Next-state and accumulator update for the syllable shifter
    always_comb begin
        start_s    = SYNC & BITEN;
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        pa_nx_s    = pa_r;
        pb_nx_s    = pb_r;
        dif_nx_s   = dif_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nx_s = ST_SHIFT;
                    pa_nx_s    = SAA;
                    pb_nx_s    = SAB;
                    dif_nx_s   = SAA ^ SAB;
                    cnt_nx_s   = CNT_ONE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (start_s) begin
                    // A new SYNC aborts the partial syllable and takes this bit as bit 0
                    state_nx_s = ST_SHIFT;
                    pa_nx_s    = SAA;
                    pb_nx_s    = SAB;
                    dif_nx_s   = SAA ^ SAB;
                    cnt_nx_s   = CNT_ONE;
                end else if (BITEN) begin
                    pa_nx_s    = pa_r ^ SAA;
                    pb_nx_s    = pb_r ^ SAB;
                    dif_nx_s   = dif_r | (SAA ^ SAB);
                    cnt_nx_s   = cnt_r + CNT_ONE;
                    state_nx_s = (cnt_r == LAST_CNT) ? ST_CHECK : ST_SHIFT;
                end else begin
                    state_nx_s = ST_SHIFT;
                end
            end
            ST_CHECK: begin
                if (start_s) begin
                    // Back-to-back syllable: this check still completes on this edge
                    state_nx_s = ST_SHIFT;
                    pa_nx_s    = SAA;
                    pb_nx_s    = SAB;
                    dif_nx_s   = SAA ^ SAB;
                    cnt_nx_s   = CNT_ONE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = CNT_ZERO;
                pa_nx_s    = 1'b0;
                pb_nx_s    = 1'b0;
                dif_nx_s   = 1'b0;
            end
        endcase
    end

    // Shifter state, bit counter and channel accumulators
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            pa_r    <= 1'b0;
            pb_r    <= 1'b0;
            dif_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            pa_r    <= pa_nx_s;
            pb_r    <= pb_nx_s;
            dif_r   <= dif_nx_s;
            busy_r  <= (state_nx_s == ST_SHIFT);
        end
    end

    // Check strobe and held result flags; a completing check takes priority over CLRERR
    always_ff @(posedge clk) begin
        if (rst) begin
            time_r <= 1'b0;
            eap_r  <= 1'b0;
            ebp_r  <= 1'b0;
            coc_r  <= 1'b0;
            cnc_r  <= 1'b0;
        end else if (state_r == ST_CHECK) begin
            time_r <= 1'b1;
            eap_r  <= parity_err(pa_r);
            ebp_r  <= parity_err(pb_r);
            cnc_r  <= dif_r;
            coc_r  <= ~dif_r;
        end else begin
            time_r <= 1'b0;
            if (CLRERR) begin
                eap_r <= 1'b0;
                ebp_r <= 1'b0;
                coc_r <= 1'b0;
                cnc_r <= 1'b0;
            end
        end
    end

    assign TIME = time_r;
    assign EAP  = eap_r;
    assign EBP  = ebp_r;
    assign COC  = coc_r;
    assign CNC  = cnc_r;
    assign BUSY = busy_r;

`ifdef SYLLABLE_ERR_COUNT_EN
    logic [7:0] ecnta_r;
    logic [7:0] ecntb_r;

    // Saturating parity-error counters; only rst clears them
    always_ff @(posedge clk) begin
        if (rst) begin
            ecnta_r <= 8'd0;
            ecntb_r <= 8'd0;
        end else if (state_r == ST_CHECK) begin
            if (parity_err(pa_r) && (ecnta_r != 8'hFF)) begin
                ecnta_r <= ecnta_r + 8'd1;
            end
            if (parity_err(pb_r) && (ecntb_r != 8'hFF)) begin
                ecntb_r <= ecntb_r + 8'd1;
            end
        end
    end

    assign ECNTA = ecnta_r;
    assign ECNTB = ecntb_r;
`endif

endmodule

// File: tb/tb_syllable_parity_check.sv
// ----------------------------------------------------------------------------
// tb_syllable_parity_check
//
// This bench drives serial syllables into syllable_parity_check. Each expected
// flag set is queued when a syllable's parity bit is driven. The set is popped
// and compared when TIME pulses. It uses the default parameters: 13 data bits
// and odd parity.
// ----------------------------------------------------------------------------
module tb_syllable_parity_check;

    logic       clk = 1'b0;
    logic       rst;
    logic       SYNC;
    logic       BITEN;
    logic       SAA;
    logic       SAB;
    logic       CLRERR;
    logic       TIME;
    logic       EAP;
    logic       EBP;
    logic       COC;
    logic       CNC;
    logic       BUSY;
`ifdef SYLLABLE_ERR_COUNT_EN
    logic [7:0] ECNTA;
    logic [7:0] ECNTB;
`endif

    syllable_parity_check dut (
        .clk    (clk),
        .rst    (rst),
        .SYNC   (SYNC),
        .BITEN  (BITEN),
        .SAA    (SAA),
        .SAB    (SAB),
        .CLRERR (CLRERR),
        .TIME   (TIME),
        .EAP    (EAP),
        .EBP    (EBP),
        .COC    (COC),
        .CNC    (CNC),
        .BUSY   (BUSY)
`ifdef SYLLABLE_ERR_COUNT_EN
        ,
        .ECNTA  (ECNTA),
        .ECNTB  (ECNTB)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic eap;
        logic ebp;
        logic coc;
        logic cnc;
    } exp_t;

    typedef struct {
        logic [13:0] a;
        logic [13:0] b;
        logic        eap;
        logic        ebp;
        logic        coc;
        logic        cnc;
    } vec_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    int   time_cnt = 0;
    logic time_d   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: odd parity over 14 bits, channel compare
    function automatic exp_t model(input logic [13:0] a, input logic [13:0] b);
        exp_t m;
        m.eap = (($countones(a) % 2) == 0);
        m.ebp = (($countones(b) % 2) == 0);
        m.coc = (a == b);
        m.cnc = (a != b);
        return m;
    endfunction

    // Scoreboard consumer: one expected record per TIME pulse
    always @(negedge clk) begin
        exp_t e;
        if (TIME) begin
            time_cnt++;
            chk("time_width", 32'(time_d), 32'd0);
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL time_unexpected actual=TIME required=no_TIME at %0t", $time);
            end else begin
                e = sbq.pop_front();
                chk("eap", 32'(EAP), 32'(e.eap));
                chk("ebp", 32'(EBP), 32'(e.ebp));
                chk("coc", 32'(COC), 32'(e.coc));
                chk("cnc", 32'(CNC), 32'(e.cnc));
            end
        end
        time_d <= TIME;
    end

    // Drive nbits of a syllable; gap idle clocks precede bits 1..13 (never bit 0)
    task automatic send(input logic [13:0] a, input logic [13:0] b, input int nbits,
                        input int gap, input exp_t e);
        for (int i = 0; i < nbits; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    SYNC  = 1'b0;
                    BITEN = 1'b0;
                end
            end
            @(negedge clk);
            SYNC  = (i == 0);
            BITEN = 1'b1;
            SAA   = a[i];
            SAB   = b[i];
            if (i == 13) sbq.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            SYNC   = 1'b0;
            BITEN  = 1'b0;
            CLRERR = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        exp_t e;
        int   t0;

        vecs[0] = '{14'h0001, 14'h0001, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{14'h0021, 14'h0001, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{14'h0000, 14'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{14'h1FFF, 14'h1FFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{14'h3FFF, 14'h1FFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{14'h2AAA, 14'h2AAA, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{14'h1555, 14'h0555, 1'b0, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; SYNC = 1'b0; BITEN = 1'b0; SAA = 1'b0; SAB = 1'b0; CLRERR = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'({TIME, EAP, EBP, COC, CNC, BUSY}), 32'd0);
        rst = 1'b0;
        idle(2);

        // Table: back-to-back syllables, BITEN every clock
        for (int v = 0; v < 7; v++) begin
            e = '{vecs[v].eap, vecs[v].ebp, vecs[v].coc, vecs[v].cnc};
            send(vecs[v].a, vecs[v].b, 14, 0, e);
        end
        idle(4);
        chk("table_drain", 32'(sbq.size()), 32'd0);

        // Channel A error: flags hold, then CLRERR clears all four
        send(14'h0021, 14'h0001, 14, 0, model(14'h0021, 14'h0001));
        idle(6);
        chk("hold_flags", 32'({EAP, EBP, COC, CNC}), 32'b1001);
        @(negedge clk); CLRERR = 1'b1;
        @(negedge clk); CLRERR = 1'b0;
        chk("clrerr", 32'({EAP, EBP, COC, CNC}), 32'd0);

        // CLRERR during CHECK loses to the check update
        send(14'h0021, 14'h0001, 14, 0, model(14'h0021, 14'h0001));
        @(negedge clk); BITEN = 1'b0; CLRERR = 1'b1;
        @(negedge clk); CLRERR = 1'b0;
        chk("check_beats_clrerr", 32'({EAP, EBP, COC, CNC}), 32'b1001);
        idle(3);

        // Reset for 2 clocks mid-SHIFT, followed by a normal syllable
        send(14'h0001, 14'h0001, 5, 0, e);
        chk("busy_mid_shift", 32'(BUSY), 32'd1);
        @(negedge clk); rst = 1'b1; BITEN = 1'b0; SYNC = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        chk("reset_mid_shift", 32'({TIME, EAP, EBP, COC, CNC, BUSY}), 32'd0);
        send(14'h0001, 14'h0001, 14, 0, model(14'h0001, 14'h0001));
        idle(4);

        // Abort at cnt==7; TIME 14 strobes + 1 clk after the second SYNC
        chk("sb_empty_pre_abort", 32'(sbq.size()), 32'd0);
        t0 = time_cnt;
        send(14'h0021, 14'h0000, 7, 0, e);
        send(14'h0001, 14'h0001, 14, 0, model(14'h0001, 14'h0001));
        @(negedge clk); BITEN = 1'b0;
        chk("abort_time_early", 32'(TIME), 32'd0);
        @(negedge clk);
        chk("abort_time", 32'(TIME), 32'd1);
        idle(4);
        chk("abort_time_count", 32'(time_cnt - t0), 32'd1);

        // Back-to-back with BITEN every 3rd clock; SYNC lands during CHECK
        t0 = time_cnt;
        send(14'h1FFF, 14'h1FFF, 14, 2, model(14'h1FFF, 14'h1FFF));
        send(14'h0021, 14'h0001, 14, 2, model(14'h0021, 14'h0001));
        send(14'h1FFF, 14'h1FFF, 14, 2, model(14'h1FFF, 14'h1FFF));
        idle(10);
        chk("b2b_time_count", 32'(time_cnt - t0), 32'd3);
        chk("b2b_last_flags", 32'({EAP, EBP, COC, CNC}), 32'b0010);

`ifdef SYLLABLE_ERR_COUNT_EN
        // Error counters: saturate, ignore CLRERR, clear on rst
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("ecnt_reset", 32'({ECNTA, ECNTB}), 32'd0);
        for (int s = 0; s < 300; s++) begin
            send(14'h0000, 14'h0001, 14, 0, model(14'h0000, 14'h0001));
        end
        idle(5);
        chk("ecnta_sat", 32'(ECNTA), 32'd255);
        chk("ecntb_zero", 32'(ECNTB), 32'd0);
        @(negedge clk); CLRERR = 1'b1;
        @(negedge clk); CLRERR = 1'b0;
        chk("ecnta_after_clrerr", 32'(ECNTA), 32'd255);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("ecnt_after_rst", 32'({ECNTA, ECNTB}), 32'd0);
`endif

        idle(5);
        chk("sb_drain", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
